muxer_n: RTL
============

MUXER_N -- requirements
Module: muxer_n

Interface
REQ-001 SHALL have parameter CHANNELS, default 8, number of input channels (2..32).
REQ-002 SHALL have parameter WIDTH, default 1, data bits per channel (1..64).
REQ-003 SHALL derive SEL_W = $clog2(CHANNELS) locally, not as an overridable port parameter.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_data, input, CHANNELS*WIDTH, channel i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid, input, CHANNELS, per-channel valid.
REQ-008 SHALL have port in_ready, output, CHANNELS, per-channel ready.
REQ-009 SHALL have port sel, input, SEL_W, channel select in fixed mode.
REQ-010 SHALL have port mode, input, 1, 0 = fixed select, 1 = round-robin.
REQ-011 SHALL have port out_data, output, WIDTH, registered selected data.
REQ-012 SHALL have port out_valid, output, 1, out_data holds an unconsumed word.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts.
REQ-014 SHALL have port out_ch, output, SEL_W, source channel of out_data.

Function
REQ-015 SHALL define load = !out_valid || out_ready; register accepts a word only when load is 1.
REQ-016 SHALL grant at most one channel per cycle; in_ready[g] = load for granted channel g, 0 for all others.
REQ-017 SHALL, in fixed mode, grant g = sel; sel >= CHANNELS grants nothing and all in_ready stay 0.
REQ-018 SHALL, in round-robin mode, grant the first channel with in_valid=1 searching from rr_ptr+1 upward, wrapping CHANNELS-1 to 0.
REQ-019 SHALL advance rr_ptr to g only on a transfer (in_valid[g] && in_ready[g]); no transfer leaves rr_ptr unchanged.
REQ-020 SHALL, on transfer, capture in_data of g into out_data, g into out_ch, set out_valid=1 at next edge (latency 1 cycle).
REQ-021 SHALL clear out_valid when out_valid && out_ready and no new transfer occurs in the same cycle.
REQ-022 SHALL sustain one word per cycle when out_ready is held 1 (simultaneous consume and load).
REQ-023 SHALL hold out_data, out_ch, out_valid stable while out_valid=1 and out_ready=0.
REQ-024 SHALL treat sel and mode changes as effective on the grant of the same cycle; a held output word is unaffected.
REQ-025 SHALL have no combinational path from out_ready to out_data/out_valid/out_ch.

Reset
REQ-026 SHALL on rst_n=0 immediately force out_valid=0, out_data=0, out_ch=0, rr_ptr=CHANNELS-1 (channel 0 first priority).
REQ-027 SHALL drive in_ready all 0 while rst_n=0; a word held mid-backpressure is discarded.
REQ-028 SHALL resume normal operation on the first rising clk after rst_n deasserts.

Configuration
REQ-029 SHALL compile round-robin logic only when macro MUXER_N_RR_EN is defined.
REQ-030 SHALL, without MUXER_N_RR_EN, ignore mode, contain no rr_ptr, and behave as fixed mode at all times.

Verification
REQ-031 Walking one, CHANNELS=8 WIDTH=1, mode=0, all valid, out_ready=1: sel=k, in_data=1<<k for k=0..7 -> out_data=1, out_ch=k one cycle later each.
REQ-032 Walking zero, same setup: in_data=~(1<<k), sel=k -> out_data=0 every cycle; sel=k with in_data=1<<((k+1)%8) -> out_data=0.
REQ-033 Backpressure, WIDTH=8: ch3 data 0xA5 loaded, out_ready=0 for 4 cycles -> out_data=0xA5, out_valid=1 stable, in_ready=0x00; out_ready=1 -> next word loads same cycle.
REQ-034 Round-robin (macro on), mode=1, in_valid=0xFF, out_ready=1 -> out_ch sequence 0,1,..7,0; in_valid=0x24 -> 2,5,2,5.
REQ-035 Out-of-range, CHANNELS=6: sel=7 -> in_ready=0, out_valid falls to 0 after held word consumed.
REQ-036 Reset mid-stream: assert rst_n=0 while out_valid=1 under backpressure -> out_valid=0, out_data=0 without clk edge; rr restart grants channel 0 first.

Source files
------------

// File: rtl/muxer_n.sv
// N-to-1 valid/ready muxer with a one-word output register; fixed select, or round-robin when MUXER_N_RR_EN is defined.
// Latency 1 cycle; in_ready is gated by load = !out_valid || out_ready, so a stalled output stalls every input.
module muxer_n #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 1,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SEL_W-1:0]          out_ch
);

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  logic             load;
  logic             fix_vld;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic             xfer;

  assign load    = !out_valid_q || out_ready;
  assign fix_vld = 32'(sel) < 32'(CHANNELS);

`ifdef MUXER_N_RR_EN
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_vld;
  int               cand;

  // Search starts just past the last served channel and wraps once.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      if (!rr_vld && in_valid[cand]) begin
        rr_vld = 1'b1;
        rr_idx = cand[SEL_W-1:0];
      end
    end
  end

  assign rr_ptr_d = xfer ? grant_idx : rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= SEL_W'(CHANNELS - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  always_comb begin
    grant_vld = fix_vld;
    grant_idx = sel;
`ifdef MUXER_N_RR_EN
    if (mode) begin
      grant_vld = rr_vld;
      grant_idx = rr_idx;
    end
`endif
  end

  always_comb begin
    in_ready = '0;
    if (grant_vld && load && rst_n) in_ready[grant_idx] = 1'b1;
  end

  assign xfer = grant_vld && load && in_valid[grant_idx];

  always_comb begin
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_data_d = in_data[grant_idx*WIDTH +: WIDTH];
      out_ch_d   = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule
